// File: rtl/sad_pkg.sv
// sad_pkg: shared types, defaults and helpers for the SAD search engine
package sad_pkg;
  typedef enum logic [1:0] {IDLE, LOAD_REF, SEARCH, DONE} state_t;
  localparam int DEF_PIX_W = 8;
  localparam int DEF_BLK_N = 256;
  localparam int DEF_NUM_CAND = 16;
  function automatic logic [31:0] absdiff(input logic [31:0] a, input logic [31:0] b);
    return a > b ? a - b : b - a;
  endfunction
  function automatic int clog2_min1(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sad_if.sv
// sad_if: reference and candidate pixel streams with valid/ready handshakes
//   master drives ref/cand valid+data, slave (the engine) drives both readys
interface sad_if #(parameter int PIX_W = sad_pkg::DEF_PIX_W);
  logic ref_valid, ref_ready, cand_valid, cand_ready;
  logic [PIX_W-1:0] ref_data, cand_data;
  modport master (output ref_valid, ref_data, cand_valid, cand_data, input ref_ready, cand_ready);
  modport slave (input ref_valid, ref_data, cand_valid, cand_data, output ref_ready, cand_ready);
endinterface

// File: rtl/sad_ref_buffer.sv
// sad_ref_buffer: BLK_N x PIX_W register file, one write port, combinational read
//   clk, we/waddr/wdata write port, raddr/rdata read port; contents not reset
module sad_ref_buffer import sad_pkg::*; #(
  parameter int PIX_W = DEF_PIX_W,
  parameter int BLK_N = DEF_BLK_N
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(BLK_N)-1:0] waddr,
  input  logic [PIX_W-1:0]         wdata,
  input  logic [$clog2(BLK_N)-1:0] raddr,
  output logic [PIX_W-1:0]         rdata
);
  logic [PIX_W-1:0] mem_q [BLK_N];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/sad_search_engine.sv
// sad_search_engine: full-search SAD motion estimation with running minimum
//   clk, rst (async active-low), start pulse, s = ref/cand stream slave,
//   sad_valid/sad_out/sad_idx per candidate, best_sad/best_idx running min,
//   busy, done pulse. Optional SAD_EARLY_TERM_EN abandons hopeless candidates.
module sad_search_engine import sad_pkg::*; #(
  parameter int PIX_W = DEF_PIX_W,
  parameter int BLK_N = DEF_BLK_N,
  parameter int NUM_CAND = DEF_NUM_CAND,
  localparam int SAD_W = PIX_W + $clog2(BLK_N),
  localparam int IDX_W = clog2_min1(NUM_CAND)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  sad_if.slave             s,
  output logic             sad_valid,
  output logic [SAD_W-1:0] sad_out,
  output logic [IDX_W-1:0] sad_idx,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx,
  output logic             busy,
  output logic             done
);
  localparam int PC_W = $clog2(BLK_N);
  state_t state_q, state_d;
  logic [PC_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [IDX_W-1:0] cand_cnt_q, cand_cnt_d, sad_idx_q, sad_idx_d, best_idx_q, best_idx_d;
  logic [SAD_W-1:0] acc_q, acc_d, sad_out_q, sad_out_d, best_sad_q, best_sad_d;
  logic sad_valid_q, sad_valid_d;
  logic [PIX_W-1:0] ref_rd;
  logic start_go, ref_hs, cand_hs, pix_last, cand_last, ab_now;
  logic [SAD_W-1:0] diff, sum, acc_nx, result;

  assign start_go = state_q == IDLE && start;
  assign ref_hs = s.ref_valid && s.ref_ready;
  assign cand_hs = s.cand_valid && s.cand_ready;
  assign pix_last = pix_cnt_q == PC_W'(BLK_N - 1);
  assign cand_last = cand_cnt_q == IDX_W'(NUM_CAND - 1);
  assign diff = SAD_W'(absdiff(32'(s.cand_data), 32'(ref_rd)));
  assign sum = acc_q + diff;

  sad_ref_buffer #(.PIX_W(PIX_W), .BLK_N(BLK_N)) u_buf (
    .clk(clk), .we(ref_hs), .waddr(pix_cnt_q), .wdata(s.ref_data),
    .raddr(pix_cnt_q), .rdata(ref_rd)
  );

`ifdef SAD_EARLY_TERM_EN
  // once the partial sum reaches the best so far the candidate cannot win;
  // its pixels are still consumed to keep the stream aligned
  logic ab_q, ab_d;
  assign ab_now = ab_q || sum >= best_sad_q;
  assign acc_nx = ab_q ? acc_q : sum;
  always_comb ab_d = start_go ? 1'b0 : cand_hs ? !pix_last && ab_now : ab_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) ab_q <= 1'b0;
    else ab_q <= ab_d;
`else
  assign ab_now = 1'b0;
  assign acc_nx = sum;
`endif
  assign result = ab_now ? '1 : sum;

  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start) state_d = LOAD_REF;
      LOAD_REF: if (ref_hs && pix_last) state_d = SEARCH;
      SEARCH:   if (cand_hs && pix_last && cand_last) state_d = DONE;
      DONE:     state_d = IDLE;
    endcase
  end

  always_comb begin
    s.ref_ready = state_q == LOAD_REF;
    s.cand_ready = state_q == SEARCH;
    busy = state_q != IDLE;
    done = state_q == DONE;
  end

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    cand_cnt_d = cand_cnt_q;
    acc_d = acc_q;
    sad_valid_d = 1'b0;
    sad_out_d = sad_out_q;
    sad_idx_d = sad_idx_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    if (start_go) begin
      pix_cnt_d = '0;
      cand_cnt_d = '0;
      acc_d = '0;
      best_sad_d = '1;
      best_idx_d = '0;
    end else if (ref_hs) pix_cnt_d = pix_cnt_q + PC_W'(1);
    else if (cand_hs) begin
      pix_cnt_d = pix_cnt_q + PC_W'(1);
      acc_d = pix_last ? '0 : acc_nx;
      if (pix_last) begin
        sad_valid_d = 1'b1;
        sad_out_d = result;
        sad_idx_d = cand_cnt_q;
        cand_cnt_d = cand_cnt_q + IDX_W'(1);
        if (!ab_now && sum < best_sad_q) begin
          best_sad_d = sum;
          best_idx_d = cand_cnt_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pix_cnt_q <= '0;
      cand_cnt_q <= '0;
      acc_q <= '0;
      sad_valid_q <= 1'b0;
      sad_out_q <= '0;
      sad_idx_q <= '0;
      best_sad_q <= '1;
      best_idx_q <= '0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      cand_cnt_q <= cand_cnt_d;
      acc_q <= acc_d;
      sad_valid_q <= sad_valid_d;
      sad_out_q <= sad_out_d;
      sad_idx_q <= sad_idx_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
    end

  assign sad_valid = sad_valid_q;
  assign sad_out = sad_out_q;
  assign sad_idx = sad_idx_q;
  assign best_sad = best_sad_q;
  assign best_idx = best_idx_q;
endmodule

// File: tb/tb_sad_search_engine.sv
// tb_sad_search_engine: directed and randomized checks against a SAD reference model
module tb_sad_search_engine;
  localparam int PW = 8, BN = 4, NC = 3, SW = 10, IW = 2;
  localparam int BN2 = 256, NC2 = 2, SW2 = 16, IW2 = 1;
`ifdef SAD_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, start2 = 1'b0;
  logic sad_valid, busy, done, sad_valid2, busy2, done2;
  logic [SW-1:0] sad_out, best_sad;
  logic [IW-1:0] sad_idx, best_idx;
  logic [SW2-1:0] sad_out2, best_sad2;
  logic [IW2-1:0] sad_idx2, best_idx2;
  int vec = 0, miss = 0, done_cnt = 0, hs_cnt = 0, done2_cnt = 0;
  time last_hs_t = 0;
  int obs_sad[$], obs_idx[$], obs_done[$], obs_lat[$], obs2_sad[$];

  sad_if #(.PIX_W(PW)) bus();
  sad_if #(.PIX_W(PW)) bus2();

  sad_search_engine #(.PIX_W(PW), .BLK_N(BN), .NUM_CAND(NC)) dut (
    .clk(clk), .rst(rst), .start(start), .s(bus.slave),
    .sad_valid(sad_valid), .sad_out(sad_out), .sad_idx(sad_idx),
    .best_sad(best_sad), .best_idx(best_idx), .busy(busy), .done(done)
  );

  sad_search_engine #(.PIX_W(PW), .BLK_N(BN2), .NUM_CAND(NC2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .s(bus2.slave),
    .sad_valid(sad_valid2), .sad_out(sad_out2), .sad_idx(sad_idx2),
    .best_sad(best_sad2), .best_idx(best_idx2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  always @(posedge clk)
    if (bus.cand_valid && bus.cand_ready) begin
      hs_cnt++;
      last_hs_t = $time;
    end

  always @(negedge clk) begin
    if (sad_valid) begin
      obs_sad.push_back(int'(sad_out));
      obs_idx.push_back(int'(sad_idx));
      obs_done.push_back(int'(done));
      obs_lat.push_back(int'($time - last_hs_t));
    end
    if (done) done_cnt++;
    if (sad_valid2) obs2_sad.push_back(int'(sad_out2));
    if (done2) done2_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // SAD per candidate from plain arithmetic; an early-terminated candidate is
  // one whose full SAD is not strictly below the best so far
  function automatic void model(input int r[$], input int c[$], input int ones,
                                output int es[$], output int bs, output int bi);
    int bn;
    bn = r.size();
    bs = ones;
    bi = 0;
    es = {};
    for (int k = 0; k < c.size() / bn; k++) begin
      int sm;
      sm = 0;
      for (int p = 0; p < bn; p++)
        sm += c[k*bn+p] > r[p] ? c[k*bn+p] - r[p] : r[p] - c[k*bn+p];
      es.push_back(ET && sm >= bs ? ones : sm);
      if (sm < bs) begin
        bs = sm;
        bi = k;
      end
    end
  endfunction

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_ref(input int r[$], input bit gaps);
    for (int i = 0; i < r.size(); i++) begin
      bit hs;
      hs = 1'b0;
      while (!hs) begin
        bus.ref_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.ref_data = bus.ref_valid ? PW'(r[i]) : PW'($urandom);
        bus.cand_valid = gaps;
        bus.cand_data = PW'($urandom);
        @(posedge clk);
        hs = bus.ref_valid && bus.ref_ready;
        #1;
      end
    end
    bus.ref_valid = 1'b0;
    bus.cand_valid = 1'b0;
  endtask

  task automatic send_cands(input int c[$], input bit gaps, input bit inj);
    for (int i = 0; i < c.size(); i++) begin
      bit hs;
      hs = 1'b0;
      while (!hs) begin
        bus.cand_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.cand_data = bus.cand_valid ? PW'(c[i]) : PW'($urandom);
        bus.ref_valid = gaps;
        bus.ref_data = PW'($urandom);
        start = inj && i == 5;
        @(posedge clk);
        hs = bus.cand_valid && bus.cand_ready;
        #1;
      end
    end
    bus.cand_valid = 1'b0;
    bus.ref_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic run_search(input string tag, input int r[$], input int c[$], input bit gaps, input bit inj);
    int es[$];
    int bs, bi, d0, h0;
    obs_sad = {};
    obs_idx = {};
    obs_done = {};
    obs_lat = {};
    d0 = done_cnt;
    h0 = hs_cnt;
    do_start();
    send_ref(r, gaps);
    send_cands(c, gaps, inj);
    repeat (3) @(posedge clk);
    #1;
    model(r, c, (1 << SW) - 1, es, bs, bi);
    check($sformatf("%s n_sad", tag), obs_sad.size(), NC);
    for (int k = 0; k < NC; k++) begin
      check($sformatf("%s sad_out[%0d]", tag, k), obs_sad[k], es[k]);
      check($sformatf("%s sad_idx[%0d]", tag, k), obs_idx[k], k);
      check($sformatf("%s done_with[%0d]", tag, k), obs_done[k], k == NC - 1);
      check($sformatf("%s latency[%0d]", tag, k), obs_lat[k], 5);
    end
    check($sformatf("%s best_sad", tag), best_sad, bs);
    check($sformatf("%s best_idx", tag), best_idx, bi);
    check($sformatf("%s done_pulses", tag), done_cnt - d0, 1);
    check($sformatf("%s cand_handshakes", tag), hs_cnt - h0, BN * NC);
    check($sformatf("%s busy_after", tag), busy, 0);
  endtask

  initial begin
    int rq[$], cq[$], r2[$], c2[$], es2[$];
    int bs2, bi2, d0, cyc, h2;
    bus.ref_valid = 1'b0;
    bus.ref_data = '0;
    bus.cand_valid = 1'b0;
    bus.cand_data = '0;
    bus2.ref_valid = 1'b0;
    bus2.ref_data = '0;
    bus2.cand_valid = 1'b0;
    bus2.cand_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset best_sad", best_sad, 10'h3FF);
    check("reset best_idx", best_idx, 0);
    check("reset busy", busy, 0);
    check("reset ref_ready", bus.ref_ready, 0);
    check("reset cand_ready", bus.cand_ready, 0);
    check("reset sad_valid", sad_valid, 0);
    check("reset sad_out", sad_out, 0);
    check("reset done", done, 0);
    rst = 1'b1;

    run_search("basic", '{10, 20, 30, 40}, '{10, 20, 30, 40, 0, 0, 0, 0, 12, 18, 30, 41}, 1'b0, 1'b0);
    run_search("tie_less", '{0, 0, 0, 0}, '{7, 0, 0, 0, 0, 7, 0, 0, 1, 1, 1, 0}, 1'b0, 1'b0);
    run_search("tie_keep", '{0, 0, 0, 0}, '{7, 0, 0, 0, 0, 0, 0, 7, 9, 0, 0, 0}, 1'b0, 1'b0);
    run_search("backpressure", '{10, 20, 30, 40}, '{10, 20, 30, 40, 0, 0, 0, 0, 12, 18, 30, 41}, 1'b1, 1'b1);
    run_search("early_term", '{0, 0, 0, 0}, '{5, 0, 0, 0, 25, 25, 25, 25, 2, 0, 0, 0}, 1'b0, 1'b0);

    for (int t = 0; t < 3; t++) begin
      rq = {};
      cq = {};
      for (int i = 0; i < BN; i++) rq.push_back(int'($urandom_range(0, 255)));
      for (int i = 0; i < BN * NC; i++) cq.push_back(int'($urandom_range(0, 255)));
      run_search($sformatf("random%0d", t), rq, cq, t[0], 1'b0);
    end

    d0 = done_cnt;
    do_start();
    send_ref('{1, 2, 3, 4}, 1'b0);
    send_cands('{9, 9, 9, 9, 5}, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("midreset busy", busy, 0);
    check("midreset cand_ready", bus.cand_ready, 0);
    check("midreset best_sad", best_sad, 10'h3FF);
    check("midreset sad_valid", sad_valid, 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    check("midreset no_done", done_cnt - d0, 0);
    run_search("after_reset", '{200, 0, 255, 17}, '{0, 255, 0, 17, 200, 0, 255, 16, 3, 3, 3, 3}, 1'b1, 1'b0);

    for (int i = 0; i < BN2; i++) r2.push_back(0);
    for (int i = 0; i < BN2 * NC2; i++) c2.push_back(255);
    @(posedge clk);
    #1 start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    bus2.ref_valid = 1'b1;
    bus2.ref_data = '0;
    repeat (BN2) @(posedge clk);
    #1;
    bus2.ref_valid = 1'b0;
    bus2.cand_valid = 1'b1;
    bus2.cand_data = 8'hFF;
    cyc = 0;
    h2 = 0;
    while (h2 < BN2 * NC2 && cyc < 2000) begin
      @(posedge clk);
      if (bus2.cand_valid && bus2.cand_ready) h2++;
      cyc++;
      #1;
    end
    bus2.cand_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model(r2, c2, (1 << SW2) - 1, es2, bs2, bi2);
    check("extreme handshakes", h2, BN2 * NC2);
    check("extreme no_bubble_cycles", cyc, BN2 * NC2);
    check("extreme n_sad", obs2_sad.size(), NC2);
    check("extreme sad0", obs2_sad[0], es2[0]);
    check("extreme sad1", obs2_sad[1], es2[1]);
    check("extreme best_sad", best_sad2, bs2);
    check("extreme best_idx", best_idx2, bi2);
    check("extreme done_pulses", done2_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
